// File: rtl/bcd_date_counter.sv
// YY-MM-DD calendar counter held as six BCD digits, advanced by a prescaler
// terminal count or a step pulse, with a validated date-load port.
module bcd_date_counter #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_year,
  input  logic [7:0] load_month,
  input  logic [7:0] load_day,
  output logic [3:0] year_t,
  output logic [3:0] year_o,
  output logic [3:0] month_t,
  output logic [3:0] month_o,
  output logic [3:0] day_t,
  output logic [3:0] day_o,
  output logic       day_tick,
  output logic       wrap,
  output logic       load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TC_VAL = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    year_q, year_d, month_q, month_d, day_q, day_d;
  logic          tick_q, tick_d, wrap_q, wrap_d, err_q, err_d;
  logic          tc, adv, load_ok;

  function automatic logic is_leap(input logic [7:0] y);
    return (!y[4] && (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8)) ||
           ( y[4] && (y[3:0] == 4'd2 || y[3:0] == 4'd6));
  endfunction

  // Returned in BCD so it compares directly against BCD day values.
  function automatic logic [7:0] days_in_month(input logic [7:0] y, input logic [7:0] m);
    logic [7:0] r;
    case (m)
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      8'h02:                      r = is_leap(y) ? 8'h29 : 8'h28;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tc  = en && (presc_q == TC_VAL);
  assign adv = tc || step;

  // BCD ordering matches numeric ordering once every nibble is a decimal digit.
  assign load_ok = (load_year[7:4] <= 4'd9) && (load_year[3:0] <= 4'd9) &&
                   (load_month[7:4] <= 4'd9) && (load_month[3:0] <= 4'd9) &&
                   (load_day[7:4] <= 4'd9) && (load_day[3:0] <= 4'd9) &&
                   (load_month >= 8'h01) && (load_month <= 8'h12) &&
                   (load_day >= 8'h01) &&
                   (load_day <= days_in_month(load_year, load_month));

  always_comb begin
    presc_d = presc_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) begin
        year_d  = load_year;
        month_d = load_month;
        day_d   = load_day;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      if (en) presc_d = tc ? '0 : presc_q + 1'b1;
      if (adv) begin
        tick_d = 1'b1;
        if (day_q < days_in_month(year_q, month_q)) begin
          day_d = bcd_inc(day_q);
        end else begin
          day_d = 8'h01;
          if (month_q != 8'h12) begin
            month_d = bcd_inc(month_q);
          end else begin
            month_d = 8'h01;
            if (year_q == 8'h99) begin
              year_d = 8'h00;
              wrap_d = 1'b1;
            end else begin
              year_d = bcd_inc(year_q);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      year_q  <= 8'h00;
      month_q <= 8'h01;
      day_q   <= 8'h01;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign year_t   = year_q[7:4];
  assign year_o   = year_q[3:0];
  assign month_t  = month_q[7:4];
  assign month_o  = month_q[3:0];
  assign day_t    = day_q[7:4];
  assign day_o    = day_q[3:0];
  assign day_tick = tick_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule
